// File: rtl/serial_adder_ctrl_if.sv
// Handshake/bus bundle for the bit-serial add/subtract sequencer.
// The master drives requests; the slave (the sequencer) drives status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (output start, sub, a, b, input busy, done, sum, carry);
    modport slave  (input start, sub, a, b, output busy, done, sum, carry);
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract: one full-adder slice (two half adders + OR) stepped
// LSB first over WIDTH clocks, with a done pulse and held result/carry outputs.
module serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             cy_q, cy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;

    logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        ha0_s   = a_q[0] ^ b_q[0];
        ha0_c   = a_q[0] & b_q[0];
        ha1_s   = ha0_s ^ cy_q;
        ha1_c   = ha0_s & cy_q;
        fa_c    = ha0_c | ha1_c;
        shifted = {ha1_s, res_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    cy_d    = bus.sub;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Result bits enter at the top; after WIDTH steps bit 0 is the LSB.
                res_d = shifted[WIDTH-1:1];
                cy_d  = fa_c;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    sum_d   = shifted;
                    carry_d = fa_c;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl against a plain-arithmetic reference.
module tb_serial_adder_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [W:0] prev;

    always #5 clk = ~clk;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
        logic [W:0] bb;
        bb = {1'b0, (sv ? ~bv : bv)};
        return {1'b0, av} + bb + {{W{1'b0}}, sv};
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv, input bit guard);
        logic [W:0] exp;
        int done_at, ndone, nbusy;
        exp = ref_add(av, bv, sv);
        @(negedge clk);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.sub = sv;
        done_at = 0; ndone = 0; nbusy = 0;
        for (int k = 1; k <= W + 3; k++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (k == 1) chk("hold_prev", {bus.carry, bus.sum}, prev);
            if (k == W / 2) chk("hold_mid", {bus.carry, bus.sum}, prev);
            if (bus.done) begin
                ndone++;
                done_at = k;
                chk("result", {bus.carry, bus.sum}, exp);
            end
            if (guard && k < W) begin
                bus.start = (k % 3 == 0);
                bus.a     = (k % 2 == 0) ? W'(1) : W'($urandom);
                bus.b     = (k % 2 == 0) ? W'(1) : W'($urandom);
                bus.sub   = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("latency", done_at, W + 1);
        chk("ndone", ndone, 1);
        chk("nbusy", nbusy, W);
        chk("result_held", {bus.carry, bus.sum}, exp);
        prev = exp;
    endtask

    initial begin
        int first_done, last_done, ndone;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
        prev = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_res", {bus.carry, bus.sum}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        run_op(16'h0003, 16'h0005, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0003, 1'b1, 1'b0);
        run_op(16'h0003, 16'h0005, 1'b1, 1'b0);
        run_op(16'h0F0F, 16'h1234, 1'b0, 1'b1);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h1111; bus.sub = 1'b0;
        first_done = 0; last_done = 0; ndone = 0;
        for (int k = 1; k <= 3 * (W + 1); k++) begin
            @(negedge clk);
            chk("b2b_busy", bus.busy, !bus.done);
            if (bus.done) begin
                ndone++;
                if (first_done == 0) first_done = k;
                last_done = k;
                chk("b2b_sum", {bus.carry, bus.sum}, ref_add(16'h1234, 16'h1111, 1'b0));
            end
        end
        bus.start = 1'b0;
        chk("b2b_ndone", ndone, 3);
        chk("b2b_first", first_done, W + 1);
        chk("b2b_last", last_done, 3 * (W + 1));
        @(negedge clk);
        chk("b2b_stop", bus.busy, 0);
        prev = ref_add(16'h1234, 16'h1111, 1'b0);

        // Reset in the middle of a run.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hABCD; bus.b = 16'h1357; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy_pre", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 0);
        chk("mid_done", bus.done, 0);
        chk("mid_res", {bus.carry, bus.sum}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_idle", {bus.busy, bus.done}, 0);
        end
        prev = '0;

        for (int n = 0; n < 200; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), (n % 10 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
